// File: rtl/cpu_pkg.sv
// cpu_pkg: sequencer state encoding and instruction-field constants shared with the decoder
package cpu_pkg;
  typedef enum logic [2:0] {IDLE, FETCH, EXEC, MEM, WB, HALTED} seq_state_t;
  localparam logic [2:0] OP_ALU    = 3'd0;
  localparam logic [2:0] OP_LOAD   = 3'd1;
  localparam logic [2:0] OP_STORE  = 3'd2;
  localparam logic [2:0] OP_BRANCH = 3'd3;
  localparam logic [2:0] OP_HALT   = 3'd7;
  localparam logic [2:0] FUNCA_ADD = 3'd0;
  localparam logic [2:0] FUNCA_SUB = 3'd1;
  localparam logic [2:0] FUNCB_EQ  = 3'd0;
  localparam logic [2:0] FUNCB_NE  = 3'd1;
endpackage

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle fetch/exec/mem/wb sequencer sharing one memory port
module cpu_sequencer import cpu_pkg::*; #(
  parameter int PC_W    = 10,
  parameter int INSTR_W = 9,
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [PC_W-1:0]    start_pc,
  output logic               mem_req,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [INSTR_W-1:0] mem_wdata,
  input  logic [INSTR_W-1:0] mem_rdata,
  input  logic               mem_ack,
  output logic [INSTR_W-1:0] instr,
  input  logic               dec_branch,
  input  logic               dec_taken,
  input  logic               dec_halt,
  input  logic               dec_reg_write,
  input  logic               dec_mem_read,
  input  logic               dec_mem_write,
  input  logic               dec_mem_to_reg,
  input  logic [ADDR_W-1:0]  data_addr,
  input  logic [DATA_W-1:0]  store_data,
  input  logic [PC_W-1:0]    branch_target,
  output logic               reg_we,
  output logic               wb_sel,
  output logic [DATA_W-1:0]  load_data,
  output logic [PC_W-1:0]    pc,
  output logic               busy,
  output logic               done
);
  seq_state_t state, nextState;
  logic [PC_W-1:0]    pcNext, seqPc;
  logic [INSTR_W-1:0] instrNext, wdataNext;
  logic [DATA_W-1:0]  loadNext;
  logic [ADDR_W-1:0]  addrNext;
  logic               reqNext, weNext, doneNext;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pc        <= '0;
      instr     <= '0;
      load_data <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= nextState;
      pc        <= pcNext;
      instr     <= instrNext;
      load_data <= loadNext;
      mem_addr  <= addrNext;
      mem_wdata <= wdataNext;
      mem_req   <= reqNext;
      mem_we    <= weNext;
      done      <= doneNext;
    end
  end
  assign seqPc  = (dec_branch && dec_taken) ? branch_target : pc + PC_W'(1);
  assign busy   = (state != IDLE) && (state != HALTED);
  assign reg_we = (state == WB) && dec_reg_write;
  assign wb_sel = dec_mem_to_reg;
  always_comb begin
    nextState = state;
    pcNext    = pc;
    instrNext = instr;
    loadNext  = load_data;
    addrNext  = mem_addr;
    wdataNext = mem_wdata;
    reqNext   = mem_req;
    weNext    = mem_we;
    doneNext  = done;
    case (state)
      IDLE, HALTED: if (start) begin
        nextState = FETCH;
        pcNext    = start_pc;
        reqNext   = 1'b1;
        weNext    = 1'b0;
        addrNext  = ADDR_W'(start_pc);
        doneNext  = 1'b0;
      end
      FETCH: if (mem_ack) begin
        instrNext = mem_rdata;
        reqNext   = 1'b0;
        nextState = EXEC;
      end
      EXEC: if (dec_halt) begin
        nextState = HALTED;
        doneNext  = 1'b1;
      end else if (dec_mem_read || dec_mem_write) begin
        reqNext   = 1'b1;
        weNext    = dec_mem_write;
        addrNext  = data_addr;
        wdataNext = INSTR_W'(store_data);
        nextState = MEM;
      end else nextState = WB;
      // a combined read+write was issued as a write, so mem_we alone decides the load
      MEM: if (mem_ack) begin
        reqNext   = 1'b0;
        loadNext  = mem_we ? load_data : mem_rdata[DATA_W-1:0];
        nextState = WB;
      end
      WB: begin
        pcNext    = seqPc;
        reqNext   = 1'b1;
        weNext    = 1'b0;
        addrNext  = ADDR_W'(seqPc);
        nextState = FETCH;
      end
      default: nextState = IDLE;
    endcase
  end
endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: directed and randomized instruction streams against a transaction-level model
module tb_cpu_sequencer;
  logic       clk = 0, rst_n = 0, start = 0;
  logic [9:0] start_pc = '0;
  logic       mem_req, mem_we;
  logic [9:0] mem_addr;
  logic [8:0] mem_wdata, instr;
  logic [8:0] mem_rdata = '0;
  logic       mem_ack = 0;
  logic       dec_branch = 0, dec_taken = 0, dec_halt = 0, dec_reg_write = 0;
  logic       dec_mem_read = 0, dec_mem_write = 0, dec_mem_to_reg = 0;
  logic [9:0] data_addr = '0, branch_target = '0;
  logic [7:0] store_data = '0;
  logic       reg_we, wb_sel, busy, done;
  logic [7:0] load_data;
  logic [9:0] pc;
  int         compared = 0, mismatched = 0;
  logic [9:0] mPc = '0;
  logic [7:0] mLoad = '0;
  bit         mHalted = 0;

  cpu_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_pc(start_pc),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .instr(instr),
    .dec_branch(dec_branch), .dec_taken(dec_taken), .dec_halt(dec_halt),
    .dec_reg_write(dec_reg_write), .dec_mem_read(dec_mem_read),
    .dec_mem_write(dec_mem_write), .dec_mem_to_reg(dec_mem_to_reg),
    .data_addr(data_addr), .store_data(store_data), .branch_target(branch_target),
    .reg_we(reg_we), .wb_sel(wb_sel), .load_data(load_data), .pc(pc),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic serve(input int dly, input logic [8:0] data);
    for (int i = 1; i < dly; i++) begin
      chk("reqHeld", 32'(mem_req), 1);
      @(negedge clk);
    end
    mem_ack = 1;
    mem_rdata = data;
    @(negedge clk);
    mem_ack = 0;
    mem_rdata = 9'($urandom);
  endtask

  task automatic startAt(input logic [9:0] p);
    start = 1;
    start_pc = p;
    @(negedge clk);
    start = 0;
    start_pc = 10'($urandom);
    mPc = p;
    mHalted = 0;
    chk("startDone", 32'(done), 0);
    chk("startBusy", 32'(busy), 1);
  endtask

  task automatic runInstr(input logic [8:0] iw, input bit br, tk, hlt, rw, mr, mw, m2r,
                          input logic [9:0] tgt, dAddr, input logic [7:0] sData,
                          input logic [8:0] rd, input int fd, md);
    chk("fetchReq", 32'(mem_req), 1);
    chk("fetchAddr", 32'(mem_addr), 32'(mPc));
    chk("fetchWe", 32'(mem_we), 0);
    chk("pc", 32'(pc), 32'(mPc));
    dec_branch = br; dec_taken = tk; dec_halt = hlt; dec_reg_write = rw;
    dec_mem_read = mr; dec_mem_write = mw; dec_mem_to_reg = m2r;
    branch_target = tgt; data_addr = dAddr; store_data = sData;
    serve(fd, iw);
    chk("instr", 32'(instr), 32'(iw));
    chk("execRegWe", 32'(reg_we), 0);
    if (hlt) begin
      @(negedge clk);
      chk("haltDone", 32'(done), 1);
      chk("haltBusy", 32'(busy), 0);
      chk("haltReq", 32'(mem_req), 0);
      mHalted = 1;
      return;
    end
    @(negedge clk);
    if (mr || mw) begin
      chk("dataReq", 32'(mem_req), 1);
      chk("dataAddr", 32'(mem_addr), 32'(dAddr));
      chk("dataWe", 32'(mem_we), 32'(mw));
      if (mw) chk("dataWdata", 32'(mem_wdata), 32'(sData));
      serve(md, rd);
      if (mr && !mw) mLoad = rd[7:0];
    end
    chk("wbRegWe", 32'(reg_we), 32'(rw));
    chk("wbSel", 32'(wb_sel), 32'(m2r));
    chk("loadData", 32'(load_data), 32'(mLoad));
    mPc = (br && tk) ? tgt : mPc + 10'd1;
    @(negedge clk);
    chk("regWeOnce", 32'(reg_we), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("rstReq", 32'(mem_req), 0);
    chk("rstBusy", 32'(busy), 0);
    chk("rstDone", 32'(done), 0);
    chk("rstPc", 32'(pc), 0);
    chk("rstInstr", 32'(instr), 0);
    chk("rstLoad", 32'(load_data), 0);
    chk("rstRegWe", 32'(reg_we), 0);
    mem_ack = 1;
    @(negedge clk);
    mem_ack = 0;
    chk("idleAckIgnored", 32'(busy), 0);
    // asynchronous reset in the middle of a fetch
    startAt(10'h155);
    chk("midFetchReq", 32'(mem_req), 1);
    #2 rst_n = 0;
    #1;
    chk("asyncRstReq", 32'(mem_req), 0);
    chk("asyncRstBusy", 32'(busy), 0);
    chk("asyncRstPc", 32'(pc), 0);
    @(negedge clk);
    rst_n = 1;
    mLoad = '0;
    @(negedge clk);
    // ALU op, then start while busy must be ignored
    startAt(10'h010);
    start = 1;
    start_pc = 10'h222;
    @(negedge clk);
    start = 0;
    runInstr(9'h041, 0, 0, 0, 1, 0, 0, 0, 10'h0, 10'h0, 8'h0, 9'h0, 1, 1);
    runInstr(9'h0C2, 0, 0, 0, 1, 1, 0, 1, 10'h0, 10'h0A5, 8'h0, 9'h1C3, 1, 3);
    runInstr(9'h103, 0, 0, 0, 0, 0, 1, 0, 10'h0, 10'h033, 8'h7E, 9'h0AA, 2, 1);
    runInstr(9'h104, 0, 0, 0, 0, 1, 1, 0, 10'h0, 10'h044, 8'h5A, 9'h0FF, 1, 2);
    runInstr(9'h000, 0, 0, 0, 0, 0, 0, 0, 10'h0, 10'h0, 8'h0, 9'h0, 1, 1);
    runInstr(9'h1FF, 0, 0, 1, 0, 0, 0, 0, 10'h0, 10'h0, 8'h0, 9'h0, 1, 1);
    mem_ack = 1;
    @(negedge clk);
    mem_ack = 0;
    chk("haltAckIgnored", 32'(busy), 0);
    chk("haltDoneHeld", 32'(done), 1);
    // branch wrap cases around the top of the address space
    startAt(10'h3FF);
    runInstr(9'h181, 1, 1, 0, 0, 0, 0, 0, 10'h005, 10'h0, 8'h0, 9'h0, 1, 1);
    runInstr(9'h182, 1, 1, 0, 0, 0, 0, 0, 10'h3FF, 10'h0, 8'h0, 9'h0, 1, 1);
    runInstr(9'h183, 1, 0, 0, 0, 0, 0, 0, 10'h123, 10'h0, 8'h0, 9'h0, 1, 1);
    runInstr(9'h184, 0, 1, 0, 1, 0, 0, 0, 10'h2AA, 10'h0, 8'h0, 9'h0, 1, 1);
    runInstr(9'h1FF, 0, 0, 1, 0, 0, 0, 0, 10'h0, 10'h0, 8'h0, 9'h0, 1, 1);
    repeat (4) begin
      @(negedge clk);
      chk("haltedNoReq", 32'(mem_req), 0);
    end
    startAt(10'h100);
    for (int n = 0; n < 80; n++) begin
      if (mHalted) startAt(10'($urandom));
      runInstr(9'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 9) == 0,
               1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
               10'($urandom), 10'($urandom), 8'($urandom), 9'($urandom),
               $urandom_range(1, 4), $urandom_range(1, 4));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
